// File: rtl/lcd_command_sequencer.sv
// lcd_command_sequencer
// Feeds the single-instruction LCD transmitter: the fixed configuration list,
// then a 2x16 character message read from an external ROM. Each entry is issued
// as a 10-bit {RS,RW,D[7:0]} word with a one-cycle next_instruction strobe. The
// sequencer then waits for the transmitter's done pulse and the LCD execution
// delay before fetching the next entry.
module lcd_command_sequencer #(
  parameter int WAIT_CMD_CYCLES   = 2000,
  parameter int WAIT_CLEAR_CYCLES = 82000,
  parameter int CNT_W             = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic [4:0] char_addr,
  input  logic [7:0] char_data,
  output logic       next_instruction,
  output logic [9:0] db,
  input  logic       done,
  output logic       seq_done
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_ISSUE     = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_DELAY     = 3'd4;
  localparam logic [2:0] S_FINISH    = 3'd5;

  localparam logic [5:0] CLEAR_STEP = 6'd3;
  localparam logic [5:0] LAST_STEP  = 6'd37;

  // Counter reload values: the DELAY state lasts exactly N cycles, counting N-1 down to 0.
  localparam logic [CNT_W-1:0] CMD_LOAD   = CNT_W'(WAIT_CMD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(WAIT_CLEAR_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [5:0]       step_q, step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       db_q, db_d;
  logic [4:0]       addr_q, addr_d;
  logic [5:0]       step_inc;

  // Steps 5..20 write line 1 characters, 22..37 write line 2 characters.
  function automatic logic is_char_step(input logic [5:0] s);
    return ((s >= 6'd5) && (s <= 6'd20)) || ((s >= 6'd22) && (s <= 6'd37));
  endfunction

  // Message byte index for a character step (line 2 skips the 0xC0 address step).
  function automatic logic [4:0] char_index(input logic [5:0] s);
    logic [5:0] idx;
    idx = (s <= 6'd20) ? (s - 6'd5) : (s - 6'd6);
    return idx[4:0];
  endfunction

  // Instruction word for a step: fixed commands use RS=0, character writes use RS=1.
  function automatic logic [9:0] step_word(input logic [5:0] s, input logic [7:0] ch);
    case (s)
      6'd0:    return 10'h028;
      6'd1:    return 10'h006;
      6'd2:    return 10'h00C;
      6'd3:    return 10'h001;
      6'd4:    return 10'h080;
      6'd21:   return 10'h0C0;
      default: return {2'b10, ch};
    endcase
  endfunction

  assign step_inc = step_q + 6'd1;

  // Next-state logic. char_addr is advanced on the transition into FETCH so the
  // ROM byte is already valid while FETCH registers the instruction word.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          step_d  = 6'd0;
        end
      end
      S_FETCH: begin
        db_d    = step_word(step_q, char_data);
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (done) begin
          cnt_d   = (step_q == CLEAR_STEP) ? CLEAR_LOAD : CMD_LOAD;
          state_d = S_DELAY;
        end
      end
      S_DELAY: begin
        if (cnt_q == '0) begin
          if (step_q == LAST_STEP) begin
            state_d = S_FINISH;
          end else begin
            step_d  = step_inc;
            state_d = S_FETCH;
            if (is_char_step(step_inc)) begin
              addr_d = char_index(step_inc);
            end
          end
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, step, delay counter, instruction word and ROM address registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      step_q  <= 6'd0;
      cnt_q   <= '0;
      db_q    <= 10'h000;
      addr_q  <= 5'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      addr_q  <= addr_d;
    end
  end

  assign db               = db_q;
  assign char_addr        = addr_q;
  assign next_instruction = (state_q == S_ISSUE);
  assign seq_done         = (state_q == S_FINISH);
  assign busy             = (state_q == S_FETCH) || (state_q == S_ISSUE) ||
                            (state_q == S_WAIT_DONE) || (state_q == S_DELAY);

endmodule

// File: tb/tb_lcd_command_sequencer.sv
// Testbench for lcd_command_sequencer: transmitter model answering each
// next_instruction with a done pulse, combinational message ROM, per-run
// expectation table of the 38 instruction words, gaps and ROM addresses.
module tb_lcd_command_sequencer;

  localparam int CMD    = 20;
  localparam int CLR    = 60;
  localparam int LAT    = 100;
  localparam int BUDGET = 20000;

  logic       clk = 1'b0;
  logic       reset, start, done, busy, next_instruction, seq_done;
  logic [4:0] char_addr;
  logic [7:0] char_data;
  logic [9:0] db;
  logic       done_x, done_inj;
  logic [7:0] rom [32];

  assign done      = done_x | done_inj;
  assign char_data = rom[char_addr];

  lcd_command_sequencer #(
    .WAIT_CMD_CYCLES  (CMD),
    .WAIT_CLEAR_CYCLES(CLR),
    .CNT_W            (17)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .busy            (busy),
    .char_addr       (char_addr),
    .char_data       (char_data),
    .next_instruction(next_instruction),
    .db              (db),
    .done            (done),
    .seq_done        (seq_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [9:0] db;
    int         gap;
    int         addr;
  } vec_t;

  logic [9:0] log_db   [256];
  logic [4:0] log_addr [256];
  int         log_cyc  [256];
  int         log_gap  [256];
  int         n_pulse = 0;
  int         n_sdone = 0;
  int         sd_cyc  = 0;
  logic       sd_busy;
  int         last_done_cyc = 0;
  int         n_vec = 0;
  int         n_bad = 0;

  // Monitor: log every issued word and every seq_done pulse.
  always @(negedge clk) begin
    if (next_instruction && n_pulse < 256) begin
      log_db[n_pulse]   = db;
      log_addr[n_pulse] = char_addr;
      log_cyc[n_pulse]  = cyc;
      log_gap[n_pulse]  = cyc - last_done_cyc;
      n_pulse++;
    end
    if (seq_done) begin
      n_sdone++;
      sd_cyc  = cyc;
      sd_busy = busy;
    end
  end

  // Transmitter model: done pulse LAT cycles after each next_instruction.
  initial begin
    done_x = 1'b0;
    forever begin
      @(negedge clk);
      if (next_instruction) begin
        repeat (LAT) @(posedge clk);
        #1 done_x = 1'b1;
        last_done_cyc = cyc;
        @(posedge clk);
        #1 done_x = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // One complete sequence from start to seq_done, optionally with disturbing inputs.
  task automatic run_full(input string tag, input logic with_done, input logic disturb,
                          output int base);
    vec_t tbl [38];
    int   sbase, t, cnt, start_cyc;
    logic b_first;
    for (int s = 0; s < 38; s++) begin
      tbl[s].addr = -1;
      case (s)
        0:       tbl[s].db = 10'h028;
        1:       tbl[s].db = 10'h006;
        2:       tbl[s].db = 10'h00C;
        3:       tbl[s].db = 10'h001;
        4:       tbl[s].db = 10'h080;
        21:      tbl[s].db = 10'h0C0;
        default: begin
          tbl[s].addr = (s <= 20) ? s - 5 : s - 6;
          tbl[s].db   = {2'b10, rom[tbl[s].addr]};
        end
      endcase
      tbl[s].gap = (s == 4) ? CLR + 2 : CMD + 2;
    end
    base  = n_pulse;
    sbase = n_sdone;
    @(posedge clk);
    #1;
    chk({tag, " busy_idle"}, busy, 1'b0);
    start     = 1'b1;
    done_inj  = with_done;
    start_cyc = cyc;
    t         = 0;
    b_first   = 1'b0;
    while (n_sdone == sbase && t < BUDGET) begin
      @(posedge clk);
      #1;
      t++;
      if (t == 1) b_first = busy;
      start    = disturb && (n_pulse - base == 11) && (cyc == log_cyc[base + 10] + 30);
      done_inj = disturb && (((n_pulse - base == 8)  && (cyc == last_done_cyc + 5)) ||
                             ((n_pulse - base == 13) && (cyc == last_done_cyc + CMD + 2)));
    end
    start    = 1'b0;
    done_inj = 1'b0;
    if (t >= BUDGET) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s timeout: no seq_done within %0d cycles", tag, BUDGET);
    end
    cnt = n_pulse - base;
    chk({tag, " pulses"}, cnt, 38);
    chk({tag, " busy_after_start"}, b_first, 1'b1);
    if (cnt > 0) chk({tag, " start_latency"}, log_cyc[base] - start_cyc, 2);
    for (int s = 0; s < 38 && s < cnt; s++) begin
      chk($sformatf("%s db[%0d]", tag, s), log_db[base + s], tbl[s].db);
      if (s > 0) chk($sformatf("%s gap[%0d]", tag, s), log_gap[base + s], tbl[s].gap);
      if (tbl[s].addr >= 0)
        chk($sformatf("%s addr[%0d]", tag, s), log_addr[base + s], tbl[s].addr);
    end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, " seq_done_count"}, n_sdone - sbase, 1);
    chk({tag, " busy_at_seq_done"}, sd_busy, 1'b0);
    chk({tag, " seq_done_delay"}, sd_cyc - last_done_cyc, CMD + 1);
    chk({tag, " busy_end"}, busy, 1'b0);
    chk({tag, " pulses_end"}, n_pulse - base, 38);
  endtask

  initial begin
    int base, t;
    reset    = 1'b0;
    start    = 1'b0;
    done_inj = 1'b0;
    for (int i = 0; i < 32; i++) rom[i] = 8'h30 + 8'(i);

    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", busy, 1'b0);
    chk("rst next_instruction", next_instruction, 1'b0);
    chk("rst seq_done", seq_done, 1'b0);
    chk("rst db", db, 10'h000);
    chk("rst char_addr", char_addr, 5'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Plain run with ROM "0123...".
    run_full("runA", 1'b0, 1'b0, base);
    chk("runA db[5]", log_db[base + 5], 10'h230);
    chk("runA db[20]", log_db[base + 20], 10'h23F);

    // Line wrap, start+done together at IDLE, start/done disturbances mid-run.
    rom[15] = 8'h41;
    rom[16] = 8'h42;
    run_full("runB", 1'b1, 1'b1, base);
    chk("wrap db[20]", log_db[base + 20], 10'h241);
    chk("wrap db[21]", log_db[base + 21], 10'h0C0);
    chk("wrap db[22]", log_db[base + 22], 10'h242);
    chk("wrap addr[20]", log_addr[base + 20], 5'd15);
    chk("wrap addr[22]", log_addr[base + 22], 5'd16);
    rom[15] = 8'h3F;
    rom[16] = 8'h40;

    // Reset in the middle of step 20.
    base = n_pulse;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    t = 0;
    while (n_pulse - base < 21 && t < BUDGET) begin
      @(posedge clk);
      t++;
    end
    if (t >= BUDGET) begin
      n_vec++;
      n_bad++;
      $display("FAIL midreset timeout: step 20 not reached within %0d cycles", BUDGET);
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #2;
    chk("midrst busy", busy, 1'b0);
    chk("midrst next_instruction", next_instruction, 1'b0);
    chk("midrst seq_done", seq_done, 1'b0);
    chk("midrst db", db, 10'h000);
    chk("midrst char_addr", char_addr, 5'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (LAT + 20) @(posedge clk);

    run_full("runC", 1'b0, 1'b0, base);
    chk("restart db[0]", log_db[base], 10'h028);
    chk("restart addr[5]", log_addr[base + 5], 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
